bit_serializer: RTL and testbench

- Parallel-to-serial front end that feeds the serial input of the downstream sequence-detector FSM (my_fsm), one bit per clock.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out in a configurable bit order.
- Frames run back-to-back with no gap cycles when the producer keeps up.
- Flags each data-bearing cycle and each frame end.

---
 rtl/serdes_pkg.sv | 17 +
 rtl/bit_serializer.sv | 81 ++++++++
 tb/tb_bit_serializer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer and the downstream FSM bench:
// controller states, counter-width helper and the default word width.
package serdes_pkg;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Width needed to count 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words on valid/ready and
// streams them one bit per clock, back-to-back when the producer keeps up.
module bit_serializer
    import serdes_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int             CW       = clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] sreg_rest;
    logic             first_bit;
    logic             next_bit;
    logic             last_bit;
    logic             accept;

    // The shift register holds only the bits not yet presented; the bit on
    // ser_out is already peeled off, so it empties to zero at frame end.
    assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign next_bit  = MSB_FIRST ? sreg[WIDTH-1]      : sreg[0];
    assign load_rest = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0}
                                 : {1'b0, load_data[WIDTH-1:1]};
    assign sreg_rest = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, sreg[WIDTH-1:1]};

    assign cnt_nxt    = bit_cnt + 1'b1;
    assign last_bit   = (state == S_SHIFT) && (bit_cnt == LAST_CNT);
    assign load_ready = (state == S_IDLE) || last_bit;
    assign accept     = load_ready && load_valid;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (accept) begin
            state      <= S_SHIFT;
            bit_cnt    <= '0;
            sreg       <= load_rest;
            ser_out    <= first_bit;
            ser_valid  <= 1'b1;
            frame_done <= 1'b0;
            busy       <= 1'b1;
        end else if (last_bit) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            ser_out    <= IDLE_LEVEL;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else if (state == S_SHIFT) begin
            bit_cnt    <= cnt_nxt;
            sreg       <= sreg_rest;
            ser_out    <= next_bit;
            frame_done <= (cnt_nxt == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an 8-bit MSB-first instance and a
// 4-bit LSB-first instance share clock and reset.
module tb_bit_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, ser_a, sval_a, done_a, busy_a;
    logic [3:0] data_b;
    logic       valid_b;
    logic       ready_b, ser_b, sval_b, done_b, busy_b;

    int errors = 0;
    int checks = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
        .clock(clock), .reset(reset), .load_data(data_a), .load_valid(valid_a),
        .load_ready(ready_a), .ser_out(ser_a), .ser_valid(sval_a),
        .frame_done(done_a), .busy(busy_a)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
        .clock(clock), .reset(reset), .load_data(data_b), .load_valid(valid_b),
        .load_ready(ready_b), .ser_out(ser_b), .ser_valid(sval_b),
        .frame_done(done_b), .busy(busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Observed vector order: {ser_valid, ser_out, frame_done, busy, load_ready}
    task automatic test_reset();
        logic [4:0] obs;
        reset = 1'b0; valid_a = 1'b1; data_a = 8'hFF; valid_b = 1'b1; data_b = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            obs = {sval_a, ser_a, done_a, busy_a, ready_a};
            checks++;
            if (obs !== 5'b00001) begin
                errors++;
                $display("FAIL reset_a[%0d]: got %b expected 00001", i, obs);
            end
            obs = {sval_b, ser_b, done_b, busy_b, ready_b};
            checks++;
            if (obs !== 5'b00001) begin
                errors++;
                $display("FAIL reset_b[%0d]: got %b expected 00001", i, obs);
            end
        end
        reset = 1'b1; valid_a = 1'b0; valid_b = 1'b0;
        step();
        obs = {sval_a, ser_a, done_a, busy_a, ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release: got %b expected 00001", obs);
        end
    endtask

    task automatic test_msb_frame();
        logic [7:0] bits;
        logic [4:0] obs, exp;
        bits = 8'hA5;
        data_a = 8'hA5; valid_a = 1'b1;
        step();
        valid_a = 1'b0; data_a = 8'h00;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, bits[7-i], (i == 7), 1'b1, (i == 7)};
            obs = {sval_a, ser_a, done_a, busy_a, ready_a};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL msb_frame bit%0d: got %b expected %b", i, obs, exp);
            end
            step();
        end
        obs = {sval_a, ser_a, done_a, busy_a, ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL msb_frame_idle: got %b expected 00001", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bits;
        logic [4:0]  obs, exp;
        bits = 16'b1111000000001111;
        data_a = 8'hF0; valid_a = 1'b1;
        step();
        data_a = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            exp = {1'b1, bits[15-i], (i == 7 || i == 15), 1'b1, (i == 7 || i == 15)};
            obs = {sval_a, ser_a, done_a, busy_a, ready_a};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back bit%0d: got %b expected %b", i, obs, exp);
            end
            if (i == 15) valid_a = 1'b0;
            step();
        end
        obs = {sval_a, ser_a, done_a, busy_a, ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL back_to_back_idle: got %b expected 00001", obs);
        end
    endtask

    task automatic test_lsb_frame();
        logic [3:0] bits;
        logic [4:0] obs, exp;
        bits = 4'b0001;
        data_b = 4'b0001; valid_b = 1'b1;
        step();
        valid_b = 1'b0; data_b = 4'hF;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b1, bits[i], (i == 3), 1'b1, (i == 3)};
            obs = {sval_b, ser_b, done_b, busy_b, ready_b};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL lsb_frame bit%0d: got %b expected %b", i, obs, exp);
            end
            step();
        end
        obs = {sval_b, ser_b, done_b, busy_b, ready_b};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL lsb_frame_idle: got %b expected 00001", obs);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bits;
        logic [4:0] obs, exp;
        data_a = 8'hFF; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = {sval_a, ser_a, done_a, busy_a, ready_a};
            checks++;
            if (obs !== 5'b11010) begin
                errors++;
                $display("FAIL mid_frame_pre bit%0d: got %b expected 11010", i, obs);
            end
            if (i == 3) begin
                reset = 1'b0;
                valid_a = 1'b1;
                data_a = 8'hFF;
            end
            step();
        end
        obs = {sval_a, ser_a, done_a, busy_a, ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL mid_frame_reset: got %b expected 00001", obs);
        end
        reset = 1'b1;
        bits = 8'h81;
        data_a = 8'h81; valid_a = 1'b1;
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp = {1'b1, bits[7-i], (i == 7), 1'b1, (i == 7)};
            obs = {sval_a, ser_a, done_a, busy_a, ready_a};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_frame_restart bit%0d: got %b expected %b", i, obs, exp);
            end
            step();
        end
        obs = {sval_a, ser_a, done_a, busy_a, ready_a};
        checks++;
        if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL mid_frame_final_idle: got %b expected 00001", obs);
        end
    endtask

    initial begin
        reset = 1'b0; valid_a = 1'b0; data_a = '0; valid_b = 1'b0; data_b = '0;
        test_reset();
        test_msb_frame();
        test_back_to_back();
        test_lsb_frame();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
